// File: rtl/mem_write_stream_arbiter.sv
// mem_write_stream_arbiter
// Packet-granular round-robin arbiter that merges NUM_REQ producer streams
// onto the single input stream of the mem_write kernel. A grant is held from
// the first beat until the tlast beat completes, followed by one IDLE cycle.
// A stall watchdog raises `block` when the granted transfer stops moving.
// Optional build macro: MEM_WRITE_ARB_STATS_EN adds per-requester completed
// packet counters on pkt_count; without it pkt_count is tied to zero.
module mem_write_stream_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 64,
    parameter int STALL_LIMIT = 1024,
    parameter int CNT_W       = 16,
    localparam int GRANT_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_tvalid,
    output logic [NUM_REQ-1:0]         req_tready,
    input  logic [NUM_REQ*DATA_W-1:0]  req_tdata,
    input  logic [NUM_REQ-1:0]         req_tlast,
    output logic                       out_tvalid,
    input  logic                       out_tready,
    output logic [DATA_W-1:0]          out_tdata,
    output logic                       out_tlast,
    output logic [GRANT_W-1:0]         grant_id,
    output logic                       busy,
    output logic                       block,
    output logic [NUM_REQ*CNT_W-1:0]   pkt_count
);

    localparam logic [CNT_W-1:0]   STALL_MAX = CNT_W'(STALL_LIMIT);
    localparam logic [GRANT_W-1:0] LAST_IDX  = GRANT_W'(NUM_REQ - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state;
    logic [GRANT_W-1:0] rr_ptr;
    logic [CNT_W-1:0]   stall_cnt;
    logic [DATA_W-1:0]  data_arr [NUM_REQ];
    logic               active;
    logic               hs;
    logic               pkt_done;
    logic               sel_found;
    logic [GRANT_W-1:0] sel_idx;

    genvar i;
    for (i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_tdata[i*DATA_W +: DATA_W];
    end

    // Forwarding is suppressed while reset is high so an abandoned grant
    // cannot leak a beat in the reset cycle itself.
    assign active   = (state == GRANT) && !reset;
    assign busy     = (state == GRANT);
    assign hs       = out_tvalid & out_tready;
    assign pkt_done = hs & out_tlast;

    // Pass-through of the granted requester; everyone else is held off.
    always_comb begin
        req_tready = '0;
        out_tvalid = 1'b0;
        out_tdata  = '0;
        out_tlast  = 1'b0;
        if (active) begin
            out_tvalid           = req_tvalid[grant_id];
            out_tdata            = data_arr[grant_id];
            out_tlast            = req_tlast[grant_id];
            req_tready[grant_id] = out_tready;
        end
    end

    // Round-robin search starting at rr_ptr; walking the offsets downwards
    // lets the smallest offset overwrite the others and win.
    always_comb begin
        int                 j;
        logic [GRANT_W-1:0] idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        j         = 0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            idx = GRANT_W'(j);
            if (req_tvalid[idx]) begin
                sel_found = 1'b1;
                sel_idx   = idx;
            end
        end
    end

    // Arbitration FSM with stall watchdog.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            block     <= 1'b0;
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    block     <= 1'b0;
                    if (sel_found) begin
                        grant_id <= sel_idx;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (hs) begin
                        stall_cnt <= '0;
                        block     <= 1'b0;
                    end else begin
                        if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + 1'b1;
                        if (stall_cnt == STALL_MAX) block <= 1'b1;
                    end
                    if (pkt_done) begin
                        state  <= IDLE;
                        rr_ptr <= (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_WRITE_ARB_STATS_EN
    for (i = 0; i < NUM_REQ; i++) begin : g_stats
        logic [CNT_W-1:0] cnt;
        // Completed-packet counter for requester i; wraps naturally.
        always_ff @(posedge clock) begin
            if (reset) cnt <= '0;
            else if (pkt_done && (grant_id == GRANT_W'(i))) cnt <= cnt + 1'b1;
        end
        assign pkt_count[i*CNT_W +: CNT_W] = cnt;
    end
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_mem_write_stream_arbiter.sv
// Bench for mem_write_stream_arbiter: per-requester packet queues drive the
// inputs with random valid/ready, and a transaction-level model (grant owner,
// round-robin pointer, stall run length) predicts every output each cycle.
module tb_mem_write_stream_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int SL = 8;
    localparam int CW = 4;
    localparam int GW = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [NR-1:0]    req_tvalid;
    logic [NR-1:0]    req_tready;
    logic [NR*DW-1:0] req_tdata;
    logic [NR-1:0]    req_tlast;
    logic             out_tvalid;
    logic             out_tready;
    logic [DW-1:0]    out_tdata;
    logic             out_tlast;
    logic [GW-1:0]    grant_id;
    logic             busy;
    logic             block;
    logic [NR*CW-1:0] pkt_count;

    always #5 clock = ~clock;

    mem_write_stream_arbiter #(
        .NUM_REQ(NR), .DATA_W(DW), .STALL_LIMIT(SL), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset),
        .req_tvalid(req_tvalid), .req_tready(req_tready),
        .req_tdata(req_tdata), .req_tlast(req_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready),
        .out_tdata(out_tdata), .out_tlast(out_tlast),
        .grant_id(grant_id), .busy(busy), .block(block),
        .pkt_count(pkt_count)
    );

    int checks = 0;
    int errors = 0;

    // producer queues
    logic [DW-1:0] qd [NR][$];
    bit            ql [NR][$];
    bit            consumed [NR];
    int            vprob = 100;
    int            rprob = 100;

    // reference model
    bit m_busy;
    int m_g, m_rr, run;
    int mcnt [NR];

    // grants observed on the DUT
    int g_id [$];
    int g_cyc [$];
    int cyc = 0;
    bit prev_busy;
    bit prev_block;
    int blk_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int gid(input int k);
        return (k < g_id.size()) ? g_id[k] : -1;
    endfunction

    function automatic int gcy(input int k);
        return (k < g_cyc.size()) ? g_cyc[k] : -1000;
    endfunction

    task automatic push_pkt(input int r, input int len);
        for (int b = 0; b < len; b++) begin
            qd[r].push_back({4'(r), 12'($urandom)});
            ql[r].push_back(b == len - 1);
        end
    endtask

    // One clock cycle: drive producers, check DUT against the model, advance the model.
    task automatic step();
        logic [NR-1:0] exp_rdy;
        bit            hs;
        @(negedge clock);
        for (int i = 0; i < NR; i++) begin
            if (consumed[i]) req_tvalid[i] = 1'b0;
            consumed[i] = 1'b0;
            if (!req_tvalid[i] && qd[i].size() > 0 && int'($urandom_range(99)) < vprob)
                req_tvalid[i] = 1'b1;
            req_tdata[i*DW +: DW] = (qd[i].size() > 0) ? qd[i][0] : '0;
            req_tlast[i]          = (qd[i].size() > 0) ? ql[i][0] : 1'b0;
        end
        out_tready = int'($urandom_range(99)) < rprob;
        #1;
        if (busy && !prev_busy) begin
            g_id.push_back(int'(grant_id));
            g_cyc.push_back(cyc);
        end
        if (block && !prev_block && blk_cyc < 0) blk_cyc = cyc;
        prev_busy  = busy;
        prev_block = block;
        chk("busy", busy, m_busy);
        chk("grant_id", grant_id, m_g);
        chk("block", block, run > SL);
        hs = 1'b0;
        if (m_busy) begin
            hs = req_tvalid[m_g] && out_tready;
            exp_rdy = '0;
            exp_rdy[m_g] = out_tready;
            chk("out_tvalid", out_tvalid, req_tvalid[m_g]);
            chk("req_tready", req_tready, exp_rdy);
            if (hs) begin
                chk("out_tdata", out_tdata, qd[m_g][0]);
                chk("out_tlast", out_tlast, ql[m_g][0]);
            end
        end else begin
            chk("idle_tvalid", out_tvalid, 0);
            chk("idle_tready", req_tready, 0);
        end
        if (m_busy) begin
            if (hs) begin
                run = 0;
                consumed[m_g] = 1'b1;
                if (ql[m_g][0]) begin
                    m_busy = 1'b0;
                    m_rr   = (m_g + 1) % NR;
                    mcnt[m_g]++;
                end
                void'(qd[m_g].pop_front());
                void'(ql[m_g].pop_front());
            end else begin
                run++;
            end
        end else begin
            run = 0;
            for (int k = 0; k < NR; k++) begin
                int c;
                c = (m_rr + k) % NR;
                if (req_tvalid[c]) begin
                    m_g    = c;
                    m_busy = 1'b1;
                    break;
                end
            end
        end
        cyc++;
    endtask

    task automatic chk_stats(input string tag);
        for (int i = 0; i < NR; i++) begin
`ifdef MEM_WRITE_ARB_STATS_EN
            chk(tag, pkt_count[i*CW +: CW], mcnt[i] % (1 << CW));
`else
            chk(tag, pkt_count[i*CW +: CW], 0);
`endif
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_tvalid", out_tvalid, 0);
        chk("rst_tready", req_tready, 0);
        @(negedge clock);
        req_tvalid = '0;
        for (int i = 0; i < NR; i++) begin
            qd[i].delete();
            ql[i].delete();
            consumed[i] = 1'b0;
            mcnt[i] = 0;
        end
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_block", block, 0);
        chk("rst_out_tvalid", out_tvalid, 0);
        chk("rst_pkt_count", pkt_count, 0);
        reset = 1'b0;
        m_busy = 1'b0; m_g = 0; m_rr = 0; run = 0;
        prev_busy = 1'b0; prev_block = 1'b0; blk_cyc = -1;
        g_id.delete();
        g_cyc.delete();
    endtask

    task automatic drain(input int maxc);
        int  n;
        bit  pend;
        n = 0;
        pend = 1'b1;
        while (pend && n < maxc) begin
            step();
            n++;
            pend = m_busy;
            for (int i = 0; i < NR; i++) if (qd[i].size() > 0) pend = 1'b1;
        end
        chk("drain_timeout", n >= maxc, 0);
        step();
    endtask

    initial begin
        req_tvalid = '0;
        req_tdata  = '0;
        req_tlast  = '0;
        out_tready = 1'b0;
        do_reset();

        // round-robin with everyone valid, 2-beat packets
        vprob = 100; rprob = 100;
        for (int p = 0; p < 3; p++)
            for (int r = 0; r < NR; r++) push_pkt(r, 2);
        drain(200);
        for (int k = 0; k < 5; k++) chk("rr_order", gid(k), k % NR);
        for (int k = 1; k < 5; k++) chk("rr_spacing", gcy(k) - gcy(k - 1), 3);
        chk_stats("stats_rr");

        // packet hold: requester 0 shows up during beat 2 of requester 1
        do_reset();
        push_pkt(1, 4);
        step(); step();
        push_pkt(0, 2);
        drain(100);
        chk("hold_first", gid(0), 1);
        chk("hold_next", gid(1), 0);

        // backpressure and watchdog
        do_reset();
        push_pkt(1, 3);
        rprob = 0;
        repeat (13) step();
        chk("wd_block_hi", block, 1);
        chk("wd_latency", blk_cyc - gcy(0), 9);
        rprob = 100;
        step(); step();
        chk("wd_block_lo", block, 0);
        drain(50);

        // reset in the middle of a 5-beat packet
        do_reset();
        push_pkt(2, 5);
        step(); step();
        do_reset();
        push_pkt(3, 1);
        push_pkt(1, 1);
        drain(50);
        chk("post_rst_first", gid(0), 1);
        chk("post_rst_second", gid(1), 3);

        // single-beat packets, only requesters 2 and 3
        do_reset();
        push_pkt(2, 1); push_pkt(2, 1);
        push_pkt(3, 1); push_pkt(3, 1);
        drain(50);
        for (int k = 0; k < 4; k++) chk("skip_order", gid(k), 2 + (k % 2));
        for (int k = 1; k < 4; k++) chk("skip_spacing", gcy(k) - gcy(k - 1), 2);

        // counter wrap: 17 packets from requester 0
        do_reset();
        for (int p = 0; p < 17; p++) push_pkt(0, 1);
        drain(200);
        chk_stats("stats_wrap");

        // randomized traffic
        do_reset();
        vprob = 60; rprob = 70;
        for (int p = 0; p < 200; p++)
            push_pkt(int'($urandom_range(NR - 1)), int'($urandom_range(4, 1)));
        drain(6000);
        chk_stats("stats_rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_write_stream_arbiter.md
Name: mem_write_stream_arbiter

Overview:
- Shares the single input stream of the mem_write kernel between NUM_REQ producer streams.
- Arbitration is packet-granular round-robin: a grant is held from the first beat until the tlast beat completes.
- A stall watchdog raises `block` when the granted transfer makes no progress for STALL_LIMIT cycles. This flag feeds the design's deadlock-monitor tree.

Parameters:
- NUM_REQ, 4, number of requester streams (2..16).
- DATA_W, 64, stream data width in bits.
- STALL_LIMIT, 1024, consecutive no-handshake cycles in GRANT before `block` asserts (>=1).
- CNT_W, 16, width of stall counter and optional packet counters; must satisfy 2^CNT_W > STALL_LIMIT.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_tvalid  in  NUM_REQ  per-requester valid.
- req_tready  out  NUM_REQ  per-requester ready.
- req_tdata  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- req_tlast  in  NUM_REQ  per-requester end of packet.
- out_tvalid  out  1  valid to mem_write.
- out_tready  in  1  ready from mem_write.
- out_tdata  out  DATA_W  data to mem_write.
- out_tlast  out  1  end of packet to mem_write.
- grant_id  out  max(1,$clog2(NUM_REQ))  index of the current or last granted requester.
- busy  out  1  high while in GRANT.
- block  out  1  stall watchdog flag, registered.
- pkt_count  out  NUM_REQ*CNT_W  per-requester completed-packet counters (see Optional Feature).

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0, busy=0, block=0, stall_cnt=0, pkt_count=0.
  - All req_tready=0; out_tvalid=0, out_tlast=0, out_tdata=0.
- IDLE:
  - All req_tready=0 and out_tvalid=0.
  - If any req_tvalid is high, select the first asserted index searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - Register grant_id=selected index; go to GRANT next cycle.
  - Arbitration latency is 1 cycle from request to first possible beat.
- GRANT (g=grant_id):
  - Combinational pass-through: out_tvalid=req_tvalid[g], out_tdata=req_tdata[g], out_tlast=req_tlast[g], req_tready[g]=out_tready.
  - All other req_tready=0.
  - Inactive requesters are never dropped or re-ordered; their valids are simply held off.
- Packet end: handshake (out_tvalid&out_tready) with out_tlast=1 moves to IDLE next cycle, sets rr_ptr=(g+1) mod NUM_REQ, and increments pkt_count[g].
  - Back-to-back packets therefore have a 1-cycle bubble.
- Single-beat packet (tlast on the first beat): valid; same rules apply.
- Fairness: no requester is granted twice while another requester holds tvalid continuously.
  - With all requesters valid, grant order is 0,1,2,…,NUM_REQ-1,0.
- grant_id keeps its last value in IDLE.
- busy=1 exactly while state=GRANT.
- Stall watchdog:
  - In GRANT, stall_cnt increments every cycle without a handshake, saturating at STALL_LIMIT.
  - A handshake clears it to 0; entering IDLE clears it.
  - block is registered: block<=1 in the cycle after stall_cnt reaches STALL_LIMIT.
  - block stays 1 until the next handshake or reset, and clears in the cycle after the clearing event.
- Reset mid-packet: the grant is abandoned and the FSM returns to IDLE with all reset values.
  - The remainder of the packet is the upstream's responsibility; no beat is forwarded during or in the cycle after reset.
- Simultaneous events: when a tlast handshake coincides with new requests, those requests are evaluated only in the following IDLE cycle, using the updated rr_ptr.
- Unused parameter range: NUM_REQ=1 behaves as a registered pass-through with the same 1-cycle bubble between packets.

Optional Feature:
- Macro: MEM_WRITE_ARB_STATS_EN.
- Defined: pkt_count holds NUM_REQ free-running CNT_W-bit counters.
  - Each increments on the tlast handshake of its requester and wraps from 2^CNT_W-1 to 0.
  - Cleared only by reset.
- Undefined: no counter logic is built; pkt_count is tied to all zeros and the port list is unchanged.

Test Plan:
- Round-robin: NUM_REQ=4; all req_tvalid=1 continuously; 2-beat packets; out_tready=1 -> grant_id sequence 0,1,2,3,0.
  - 2 beats per grant, 1 idle cycle between packets; 15 cycles for the first 5 packets.
- Packet hold: requester 1 sends a 4-beat packet while requester 0 asserts valid from beat 2 -> all 4 beats come from requester 1; req_tready[0]=0 throughout; requester 0 is granted next.
- Backpressure/watchdog: STALL_LIMIT=8; granted requester valid; out_tready=0 for 12 cycles -> block=1 from cycle 9 after the first stalled cycle.
  - Raise out_tready -> block=0 one cycle after the handshake; data is unchanged and no beat is lost.
- Reset mid-packet: assert reset during beat 2 of a 5-beat packet -> next cycle busy=0, out_tvalid=0, grant_id=0, block=0.
  - A new request after reset is granted starting from index 0.
- Single-beat and skip: only requesters 2 and 3 valid; rr_ptr=0; 1-beat packets -> grants 2,3,2,3 with 1-cycle bubbles.
- Stats: MEM_WRITE_ARB_STATS_EN defined; CNT_W=4; requester 0 sends 17 packets -> pkt_count[0]=1 after wrap, other counters 0.
  - With the macro undefined -> pkt_count stays 0.
